// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the 16-channel PWM peripheral.
package pwm_pkg;

    localparam int unsigned NUM_CH          = 16;
    localparam int unsigned DUTY_W          = 8;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned PRESC_W         = 8;
    localparam int unsigned CLK_DIV_DEFAULT = 13;
    localparam int unsigned ADDR_W          = 8;

    localparam logic [ADDR_W-1:0] REG_EN_OUT_LO  = 8'h00;
    localparam logic [ADDR_W-1:0] REG_EN_OUT_HI  = 8'h01;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_LO  = 8'h02;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_HI  = 8'h03;
    localparam logic [ADDR_W-1:0] REG_PWM_DUTY   = 8'h04;

    typedef struct packed {
        logic [NUM_CH-1:0] en;
        logic [NUM_CH-1:0] pwm_mode;
    } ch_cfg_t;

    // Full-scale duty forces a solid high so 0xFF never drops a step per period.
    function automatic logic duty_level(input logic [CNT_W-1:0] cnt,
                                        input logic [DUTY_W-1:0] duty);
        return (duty == '1) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler, 8-bit period counter and period-boundary pulse for the PWM block.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [CNT_W-1:0] pwm_cnt,
    output logic             wrap,
    output logic             period_start
);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               period_start_q, period_start_d;

    always_comb begin
        tick           = (presc_q == PRESC_W'(CLK_DIV - 1));
        wrap           = tick && (cnt_q == {CNT_W{1'b1}});
        presc_d        = tick ? '0 : presc_q + PRESC_W'(1);
        cnt_d          = cnt_q + CNT_W'(tick);
        period_start_d = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_cnt      = cnt_q;
    assign period_start = period_start_q;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM peripheral: period-buffered shared duty, per-channel enable/mode mux.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en_out,
    input  logic [NUM_CH-1:0] en_pwm_mode,
    input  logic [DUTY_W-1:0] pwm_duty,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    logic              tick;
    logic              wrap;
    logic [CNT_W-1:0]  pwm_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DUTY_W-1:0] duty_act_q, duty_act_d;
    logic [NUM_CH-1:0] out_q, out_d;
    logic              pwm_level;
    ch_cfg_t           cfg;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .pwm_cnt      (pwm_cnt),
        .wrap         (wrap),
        .period_start (period_start)
    );

    // Level is taken from next-state counter/duty so out lines up with period_start.
    always_comb begin
        cfg.en       = en_out;
        cfg.pwm_mode = en_pwm_mode;
        duty_act_d   = wrap ? pwm_duty : duty_act_q;
        cnt_nxt      = pwm_cnt + CNT_W'(tick);
        pwm_level    = duty_level(cnt_nxt, duty_act_d);
        out_d        = cfg.en & ((cfg.pwm_mode & {NUM_CH{pwm_level}}) | ~cfg.pwm_mode);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_act_q <= '0;
            out_q      <= '0;
        end else begin
            duty_act_q <= duty_act_d;
            out_q      <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral at CLK_DIV = 13 and CLK_DIV = 1.
module tb_pwm_peripheral;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] en_out;
    logic [15:0] en_pwm_mode;
    logic [7:0]  pwm_duty;
    logic [15:0] out13, out1;
    logic        ps13, ps1;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(13)) u_dut13 (
        .clk          (clk),
        .rst          (rst),
        .en_out       (en_out),
        .en_pwm_mode  (en_pwm_mode),
        .pwm_duty     (pwm_duty),
        .out          (out13),
        .period_start (ps13)
    );

    pwm_peripheral #(.CLK_DIV(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .en_out       (en_out),
        .en_pwm_mode  (en_pwm_mode),
        .pwm_duty     (pwm_duty),
        .out          (out1),
        .period_start (ps1)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    int   hi_cnt[16];
    int   trans0;
    int   ps_extra;
    int   per_ok;

    function automatic void push_exp(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    function automatic logic [15:0] out_of(input int which);
        return (which == 1) ? out1 : out13;
    endfunction

    function automatic logic ps_of(input int which);
        return (which == 1) ? ps1 : ps13;
    endfunction

    task automatic wait_ps(input int which, input int limit);
        int clks;
        clks = 0;
        do begin
            @(negedge clk);
            clks++;
        end while (!ps_of(which) && clks < limit);
        vectors++;
        if (ps_of(which) !== 1'b1) begin
            errors++;
            $display("FAIL wait_ps dut%0d: period_start=%b after %0d clks, required 1", which, ps_of(which), clks);
        end
    endtask

    // Entered on the sample where period_start is high; leaves on the next one.
    task automatic measure(input int which, input int len, input int chg_at, input logic [7:0] chg_val);
        logic [15:0] o, prev;
        prev = '0;
        for (int c = 0; c < 16; c++) hi_cnt[c] = 0;
        trans0   = 0;
        ps_extra = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            o = out_of(which);
            for (int c = 0; c < 16; c++) hi_cnt[c] += int'(o[c] === 1'b1);
            if (i > 0 && o[0] !== prev[0]) trans0++;
            if (i > 0 && ps_of(which) !== 1'b0) ps_extra++;
            if (i == chg_at) pwm_duty = chg_val;
            prev = o;
        end
        @(negedge clk);
        per_ok = int'(ps_of(which) === 1'b1);
    endtask

    task automatic test_reset();
        logic [31:0] obs[$];
        exp_t e;
        rst = 1'b0;
        en_out = 16'h0001; en_pwm_mode = 16'h0001; pwm_duty = 8'h80;
        #1 rst = 1'b1;
        push_exp("rst_out13", 32'h0); push_exp("rst_ps13", 32'h0);
        push_exp("rst_out1", 32'h0);  push_exp("rst_ps1", 32'h0);
        repeat (3) @(negedge clk);
        obs = '{32'(out13), 32'(ps13), 32'(out1), 32'(ps1)};
        foreach (obs[k]) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0h, required %0h", e.name, obs[k], e.val);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_enable_latency();
        logic [31:0] obs[$];
        exp_t e;
        en_out = 16'h0300; en_pwm_mode = 16'h0000;
        push_exp("en_same_clk", 32'h0); push_exp("en_next_clk", 32'h0300);
        push_exp("en_clear", 32'h0);
        #1 obs.push_back(32'(out13));
        @(negedge clk);
        obs.push_back(32'(out13));
        en_out = 16'h0000;
        @(negedge clk);
        obs.push_back(32'(out13));
        foreach (obs[k]) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0h, required %0h", e.name, obs[k], e.val);
            end
        end
    endtask

    task automatic test_basic_duty();
        logic [31:0] obs[$];
        exp_t e;
        int others;
        en_out = 16'h0001; en_pwm_mode = 16'h0001; pwm_duty = 8'h80;
        push_exp("basic_hi0", 32'd1664); push_exp("basic_hi_others", 32'd0);
        push_exp("basic_trans0", 32'd1); push_exp("basic_ps_extra", 32'd0);
        push_exp("basic_period", 32'd1);
        wait_ps(0, 4000);
        measure(0, 3328, -1, 8'h00);
        others = 0;
        for (int c = 1; c < 16; c++) others += hi_cnt[c];
        obs = '{32'(hi_cnt[0]), 32'(others), 32'(trans0), 32'(ps_extra), 32'(per_ok)};
        foreach (obs[k]) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d, required %0d", e.name, obs[k], e.val);
            end
        end
    endtask

    task automatic test_zero_full();
        logic [31:0] obs[$];
        exp_t e;
        pwm_duty = 8'h00;
        push_exp("zero_hi", 32'd0);     push_exp("zero_trans", 32'd0);
        push_exp("full_hi", 32'd3328);  push_exp("full_trans", 32'd0);
        push_exp("full_period", 32'd1);
        measure(0, 3328, -1, 8'h00);
        measure(0, 3328, 100, 8'hFF);
        obs.push_back(32'(hi_cnt[0])); obs.push_back(32'(trans0));
        measure(0, 3328, -1, 8'h00);
        obs.push_back(32'(hi_cnt[0])); obs.push_back(32'(trans0)); obs.push_back(32'(per_ok));
        foreach (obs[k]) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d, required %0d", e.name, obs[k], e.val);
            end
        end
    endtask

    task automatic test_mixed_modes();
        logic [31:0] obs[$];
        exp_t e;
        en_out = 16'hFFFF; en_pwm_mode = 16'h00FF; pwm_duty = 8'h40;
        for (int c = 0; c < 16; c++)
            push_exp($sformatf("mixed_hi[%0d]", c), (c < 8) ? 32'd832 : 32'd3328);
        measure(0, 3328, -1, 8'h00);
        measure(0, 3328, -1, 8'h00);
        for (int c = 0; c < 16; c++) obs.push_back(32'(hi_cnt[c]));
        foreach (obs[k]) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d, required %0d", e.name, obs[k], e.val);
            end
        end
    endtask

    task automatic test_mid_period_change();
        logic [31:0] obs[$];
        exp_t e;
        en_out = 16'h0001; en_pwm_mode = 16'h0001; pwm_duty = 8'h20;
        push_exp("mid_cur_hi", 32'd416); push_exp("mid_next_hi", 32'd2496);
        push_exp("mid_next_period", 32'd1);
        measure(0, 3328, -1, 8'h00);
        measure(0, 3328, 16 * 13, 8'hC0);
        obs.push_back(32'(hi_cnt[0]));
        measure(0, 3328, -1, 8'h00);
        obs.push_back(32'(hi_cnt[0])); obs.push_back(32'(per_ok));
        foreach (obs[k]) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d, required %0d", e.name, obs[k], e.val);
            end
        end
    endtask

    task automatic test_reset_mid_period();
        logic [31:0] obs[$];
        exp_t e;
        int k, hi;
        pwm_duty = 8'h80;
        push_exp("pre_rst_out0", 32'd1);   push_exp("rst_async_out", 32'h0);
        push_exp("rst_async_ps", 32'd0);   push_exp("rst_first_ps_clks", 32'd3328);
        push_exp("rst_partial_hi", 32'd0); push_exp("rst_first_hi", 32'd832);
        measure(0, 3328, -1, 8'h00);
        repeat (80 * 13 + 5) @(negedge clk);
        obs.push_back(32'(out13[0]));
        #2 rst = 1'b1;
        #1 obs.push_back(32'(out13));
        obs.push_back(32'(ps13));
        pwm_duty = 8'h40;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        k = 0; hi = 0;
        while (k < 4000) begin
            @(negedge clk);
            k++;
            if (ps13 === 1'b1) break;
            hi += int'(out13[0] === 1'b1);
        end
        obs.push_back(32'(k)); obs.push_back(32'(hi));
        measure(0, 3328, -1, 8'h00);
        obs.push_back(32'(hi_cnt[0]));
        foreach (obs[k2]) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs[k2] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0h, required %0h", e.name, obs[k2], e.val);
            end
        end
    endtask

    task automatic test_div1();
        logic [31:0] obs[$];
        exp_t e;
        en_out = 16'h0001; en_pwm_mode = 16'h0001; pwm_duty = 8'h01;
        push_exp("div1_hi", 32'd1);       push_exp("div1_trans", 32'd1);
        push_exp("div1_ps_extra", 32'd0); push_exp("div1_period", 32'd1);
        push_exp("div1_hi2", 32'd1);      push_exp("div1_period2", 32'd1);
        wait_ps(1, 600);
        measure(1, 256, -1, 8'h00);
        obs = '{32'(hi_cnt[0]), 32'(trans0), 32'(ps_extra), 32'(per_ok)};
        measure(1, 256, -1, 8'h00);
        obs.push_back(32'(hi_cnt[0])); obs.push_back(32'(per_ok));
        foreach (obs[k]) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d, required %0d", e.name, obs[k], e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_enable_latency();
        test_basic_duty();
        test_zero_full();
        test_mixed_modes();
        test_mid_period_change();
        test_reset_mid_period();
        test_div1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL have parameter CLK_DIV, default 13, meaning system clocks per PWM counter step; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; every flop is rising-edge on clk; one clock only.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port en_out  input  16  per-channel output enable; bits 7:0 are register 0x00, bits 15:8 are register 0x01.
REQ-005 SHALL have port en_pwm_mode  input  16  per-channel PWM select (1 = PWM, 0 = static high); bits 7:0 are register 0x02, bits 15:8 are register 0x03.
REQ-006 SHALL have port pwm_duty  input  8  shared duty cycle (register 0x04); 0x00 = 0 %, 0xFF = 100 %.
REQ-007 SHALL have port out  output  16  registered channel outputs.
REQ-008 SHALL have port period_start  output  1  one-clk pulse marking the first clk of each PWM period.

Function
REQ-009 SHALL contain a prescaler, 0..CLK_DIV-1, incremented every clk; tick = (prescaler == CLK_DIV-1); the prescaler wraps to 0 on tick.
REQ-010 SHALL contain an 8-bit period counter pwm_cnt, incremented on tick only; it wraps 255 -> 0 with no gap; period = 256*CLK_DIV clks.
REQ-011 SHALL hold an active duty register duty_act, loaded from pwm_duty only on the tick where pwm_cnt wraps 255 -> 0; the pwm_duty value present in that clk is the one taken.
REQ-012 SHALL ensure a pwm_duty change mid-period does not alter the current period: no glitch and no truncated or extra high time.
REQ-013 SHALL compute pwm_level = 1 when duty_act == 0xFF, otherwise (pwm_cnt < duty_act); duty 0x00 gives constant 0, and high time is duty_act*CLK_DIV clks per period.
REQ-014 SHALL register per channel i: out[i] = en_out[i] ? (en_pwm_mode[i] ? pwm_level : 1) : 0.
REQ-015 SHALL give out one clk of latency from en_out, en_pwm_mode and pwm_level; enable bits are not period-buffered.
REQ-016 SHALL assert period_start (registered) for exactly one clk, in the clk after the tick that moves pwm_cnt 255 -> 0, coincident with the first out value of the new period.
REQ-017 SHALL behave correctly with CLK_DIV = 1: tick every clk, pwm_cnt advances every clk, period = 256 clks.
REQ-018 SHALL apply the update to out and the reload of duty_act on the same tick when an enable change and a period wrap coincide, with no priority conflict.
REQ-019 SHALL treat inputs as synchronous to clk, already registered upstream; no synchronisers are inside this block.

Reset
REQ-020 SHALL, while rst = 1, force prescaler = 0, pwm_cnt = 0, duty_act = 0x00, out = 16'h0000 and period_start = 0, immediately and without waiting for clk.
REQ-021 SHALL, on rst deassertion, start at pwm_cnt = 0 with the first tick after CLK_DIV clks; duty_act stays 0 until the first wrap.
REQ-022 SHALL, on rst assertion mid-period, discard the partial period; after release, the first full period uses the pwm_duty sampled at the first wrap.

Structure
REQ-023 SHALL take from shared package pwm_pkg: NUM_CH = 16, DUTY_W = 8, CLK_DIV_DEFAULT = 13, and register address constants 0x00..0x04.
REQ-024 SHALL place prescaler, pwm_cnt and the wrap/period_start logic in one sub-module pwm_timebase (outputs tick, pwm_cnt, wrap); duty buffering and channel muxing stay in pwm_peripheral.
REQ-025 SHALL fit in 120-400 lines of RTL across both modules.

Verification
REQ-026 SHALL cover: CLK_DIV = 13, en_out = 0x0001, en_pwm_mode = 0x0001, pwm_duty = 0x80 -> out[0] high 1664 clks, low 1664 clks, period 3328 clks; all other out bits 0.
REQ-027 SHALL cover: pwm_duty = 0x00 then 0xFF, channel in PWM mode -> out constant 0 for a full period, then constant 1 for a full period with no low glitch.
REQ-028 SHALL cover: en_out = 0xFFFF, en_pwm_mode = 0x00FF, pwm_duty = 0x40 -> out[15:8] constant 1; out[7:0] high 832 of 3328 clks.
REQ-029 SHALL cover: pwm_duty changed 0x20 -> 0xC0 at pwm_cnt = 0x10 -> current period high time 416 clks; next period (after period_start) 2496 clks.
REQ-030 SHALL cover: rst pulsed at pwm_cnt = 0x50 with out[0] high -> out = 0 asynchronously; after release, first period_start at 3328 clks, first period uses the pwm_duty sampled at that wrap.
REQ-031 SHALL cover: CLK_DIV = 1, pwm_duty = 0x01 -> out[0] high exactly 1 clk every 256 clks; period_start every 256 clks.
